// File: rtl/screen_layer_arbiter_pkg.sv
// Shared types and constants for the screen layer arbiter.
package screen_arb_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_IN   = 2'b01,
      CMD_OUT  = 2'b10,
      CMD_RSVD = 2'b11
   } fade_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_IN  = 2'd1,
      ST_FADE_OUT = 2'd2
   } fade_state_e;

   localparam logic [4:0] BRIGHT_MAX = 5'd16;

endpackage

// File: rtl/screen_layer_arbiter_if.sv
// Pixel-side bundle between the layer units / game logic and the arbiter.
// SCREEN_ARB_HIT_OUT_EN adds hit_valid/hit_layer.
interface screen_layer_arbiter_if #(
   parameter int NUM_LAYERS = 4
);
   logic                          pxl_en;
   logic                          frame_start;
   logic [NUM_LAYERS-1:0]         layer_req;
   logic [12*NUM_LAYERS-1:0]      layer_rgb;
   logic [NUM_LAYERS-1:0]         cfg_mask;
   logic                          cfg_rev;
   logic [1:0]                    fade_cmd;
   logic                          fade_busy;
   logic                          fade_done;
   logic [3:0]                    Red_level;
   logic [3:0]                    Green_level;
   logic [3:0]                    Blue_level;
   logic [NUM_LAYERS-1:0]         coll_frame;
`ifdef SCREEN_ARB_HIT_OUT_EN
   logic                          hit_valid;
   logic [$clog2(NUM_LAYERS)-1:0] hit_layer;
`endif

   modport master (
      output pxl_en, frame_start, layer_req, layer_rgb, cfg_mask, cfg_rev, fade_cmd,
`ifdef SCREEN_ARB_HIT_OUT_EN
      input  hit_valid, hit_layer,
`endif
      input  fade_busy, fade_done, Red_level, Green_level, Blue_level, coll_frame
   );

   modport slave (
      input  pxl_en, frame_start, layer_req, layer_rgb, cfg_mask, cfg_rev, fade_cmd,
`ifdef SCREEN_ARB_HIT_OUT_EN
      output hit_valid, hit_layer,
`endif
      output fade_busy, fade_done, Red_level, Green_level, Blue_level, coll_frame
   );

endinterface

// File: rtl/screen_layer_arbiter_fade_ctrl.sv
// Frame-synchronous brightness fade: FSM plus frame counter, producing
// the 0..16 brightness factor and busy/done status.
module fade_ctrl
   import screen_arb_pkg::*;
#(
   parameter int FADE_STEP_FRAMES = 2
) (
   input  logic       clk_25,
   input  logic       resetN,
   input  logic       frame_start,
   input  logic [1:0] fade_cmd,
   output logic [4:0] bright,
   output logic       fade_busy,
   output logic       fade_done
);
   localparam int FC_W = $clog2(FADE_STEP_FRAMES + 1);

   fade_state_e     state_q, state_d;
   logic [FC_W-1:0] fc_q, fc_d, fc_inc;
   logic [4:0]      b_q, b_d;
   logic            done_q, done_d;
   fade_cmd_e       cmd;

   always_ff @(posedge clk_25) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         fc_q    <= '0;
         b_q     <= BRIGHT_MAX;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fc_q    <= fc_d;
         b_q     <= b_d;
         done_q  <= done_d;
      end
   end

   // Commands are only looked at in IDLE, so a frame_start coinciding with
   // an accepted command is never counted.
   always_comb begin
      cmd     = fade_cmd_e'(fade_cmd);
      state_d = state_q;
      fc_d    = fc_q;
      b_d     = b_q;
      done_d  = 1'b0;
      fc_inc  = fc_q + 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd == CMD_IN && b_q < BRIGHT_MAX) begin
               state_d = ST_FADE_IN;
               fc_d    = '0;
            end else if (cmd == CMD_OUT && b_q != 5'd0) begin
               state_d = ST_FADE_OUT;
               fc_d    = '0;
            end
         end
         ST_FADE_IN: begin
            if (frame_start) begin
               if (fc_inc == FC_W'(FADE_STEP_FRAMES)) begin
                  fc_d = '0;
                  b_d  = b_q + 5'd1;
                  if (b_q + 5'd1 == BRIGHT_MAX) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  fc_d = fc_inc;
               end
            end
         end
         ST_FADE_OUT: begin
            if (frame_start) begin
               if (fc_inc == FC_W'(FADE_STEP_FRAMES)) begin
                  fc_d = '0;
                  b_d  = b_q - 5'd1;
                  if (b_q == 5'd1) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  fc_d = fc_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fade_busy = (state_q != ST_IDLE);
      fade_done = done_q;
      bright    = b_q;
   end

endmodule

// File: rtl/screen_layer_arbiter.sv
// Per-pixel layer arbiter: priority grant, brightness scaling, per-frame collision flags.
// Build option SCREEN_ARB_HIT_OUT_EN adds pipeline-aligned hit_valid/hit_layer outputs.
module screen_layer_arbiter
   import screen_arb_pkg::*;
#(
   parameter int          NUM_LAYERS       = 4,
   parameter int          PIPE_LAT         = 2,
   parameter int          FADE_STEP_FRAMES = 2,
   parameter logic [11:0] BG_RGB           = 12'h000
) (
   input logic                   clk_25,
   input logic                   resetN,
   screen_layer_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LAYERS);

   logic [NUM_LAYERS-1:0] mask_q, mask_d;
   logic                  rev_q, rev_d;
   logic [NUM_LAYERS-1:0] req_en;
   logic                  gnt_vld;
   logic [IDX_W-1:0]      gnt_idx;
   rgb12_t                layer_pix [NUM_LAYERS];
   logic [4:0]            bri;
   logic                  fade_busy, fade_done;

   rgb12_t                pix_p1_q, pix_p1_d;
   logic [4:0]            bri_p1_q, bri_p1_d;
   rgb12_t                pix_p2_q [PIPE_LAT-1];
   rgb12_t                pix_p2_d [PIPE_LAT-1];

   logic [NUM_LAYERS-1:0] coll_hit;
   logic [NUM_LAYERS-1:0] coll_live_q, coll_live_d;
   logic [NUM_LAYERS-1:0] coll_frame_q, coll_frame_d;

   function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] b);
      logic [7:0] prod;
      prod = {4'd0, c} * {3'd0, b};
      return prod[7:4];
   endfunction

   function automatic rgb12_t scale_pix(input rgb12_t p, input logic [4:0] b);
      rgb12_t s;
      s.r = scale_chan(p.r, b);
      s.g = scale_chan(p.g, b);
      s.b = scale_chan(p.b, b);
      return s;
   endfunction

   fade_ctrl #(
      .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
   ) u_fade (
      .clk_25     (clk_25),
      .resetN     (resetN),
      .frame_start(bus.frame_start),
      .fade_cmd   (bus.fade_cmd),
      .bright     (bri),
      .fade_busy  (fade_busy),
      .fade_done  (fade_done)
   );

   // Shadowed config: a frame_start cycle already arbitrates with the new values.
   always_comb begin
      mask_d = bus.frame_start ? bus.cfg_mask : mask_q;
      rev_d  = bus.frame_start ? bus.cfg_rev  : rev_q;
   end

   always_comb begin
      req_en  = bus.layer_req & mask_d;
      gnt_vld = |req_en;
      gnt_idx = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         layer_pix[i] = bus.layer_rgb[12*i +: 12];
      end
      if (rev_d) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (req_en[i]) gnt_idx = IDX_W'(i);
         end
      end else begin
         for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req_en[i]) gnt_idx = IDX_W'(i);
         end
      end
   end

   // Stage 1: granted pixel + brightness; stage 2 onward: scale then delay.
   always_comb begin
      if (!bus.pxl_en)  pix_p1_d = '0;
      else if (gnt_vld) pix_p1_d = layer_pix[gnt_idx];
      else              pix_p1_d = BG_RGB;
      bri_p1_d    = bri;
      pix_p2_d[0] = scale_pix(pix_p1_q, bri_p1_q);
      for (int k = 1; k < PIPE_LAT - 1; k++) begin
         pix_p2_d[k] = pix_p2_q[k-1];
      end
   end

   always_comb begin
      coll_hit = (bus.pxl_en && ((req_en & (req_en - 1'b1)) != '0)) ? req_en : '0;
      if (bus.frame_start) begin
         coll_frame_d = coll_live_q;
         coll_live_d  = coll_hit;
      end else begin
         coll_frame_d = coll_frame_q;
         coll_live_d  = coll_live_q | coll_hit;
      end
   end

   always_ff @(posedge clk_25) begin
      if (!resetN) begin
         mask_q       <= '1;
         rev_q        <= 1'b0;
         pix_p1_q     <= '0;
         bri_p1_q     <= '0;
         coll_live_q  <= '0;
         coll_frame_q <= '0;
         for (int k = 0; k < PIPE_LAT - 1; k++) pix_p2_q[k] <= '0;
      end else begin
         mask_q       <= mask_d;
         rev_q        <= rev_d;
         pix_p1_q     <= pix_p1_d;
         bri_p1_q     <= bri_p1_d;
         coll_live_q  <= coll_live_d;
         coll_frame_q <= coll_frame_d;
         pix_p2_q     <= pix_p2_d;
      end
   end

   assign bus.Red_level   = pix_p2_q[PIPE_LAT-2].r;
   assign bus.Green_level = pix_p2_q[PIPE_LAT-2].g;
   assign bus.Blue_level  = pix_p2_q[PIPE_LAT-2].b;
   assign bus.coll_frame  = coll_frame_q;
   assign bus.fade_busy   = fade_busy;
   assign bus.fade_done   = fade_done;

`ifdef SCREEN_ARB_HIT_OUT_EN
   logic             hv_p1_q, hv_p1_d;
   logic [IDX_W-1:0] hl_p1_q, hl_p1_d;
   logic             hv_p2_q [PIPE_LAT-1];
   logic             hv_p2_d [PIPE_LAT-1];
   logic [IDX_W-1:0] hl_p2_q [PIPE_LAT-1];
   logic [IDX_W-1:0] hl_p2_d [PIPE_LAT-1];

   always_comb begin
      hv_p1_d    = bus.pxl_en & gnt_vld;
      hl_p1_d    = hv_p1_d ? gnt_idx : '0;
      hv_p2_d[0] = hv_p1_q;
      hl_p2_d[0] = hl_p1_q;
      for (int k = 1; k < PIPE_LAT - 1; k++) begin
         hv_p2_d[k] = hv_p2_q[k-1];
         hl_p2_d[k] = hl_p2_q[k-1];
      end
   end

   always_ff @(posedge clk_25) begin
      if (!resetN) begin
         hv_p1_q <= 1'b0;
         hl_p1_q <= '0;
         for (int k = 0; k < PIPE_LAT - 1; k++) begin
            hv_p2_q[k] <= 1'b0;
            hl_p2_q[k] <= '0;
         end
      end else begin
         hv_p1_q <= hv_p1_d;
         hl_p1_q <= hl_p1_d;
         hv_p2_q <= hv_p2_d;
         hl_p2_q <= hl_p2_d;
      end
   end

   assign bus.hit_valid = hv_p2_q[PIPE_LAT-2];
   assign bus.hit_layer = hl_p2_q[PIPE_LAT-2];
`endif

endmodule
